counter: RTL and testbench



---
 rtl/counter.sv | 28 ++
 tb/tb_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running wrap-around up-counter with a single-cycle overflow pulse.
// Both outputs are flops; nothing combinational reaches the ports.
module counter #(
  parameter int unsigned NumOfBit = 8
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Enable,
  output logic [NumOfBit-1:0] Output,
  output logic                Overflow
);

  localparam logic [NumOfBit-1:0] MaxCount = '1;

  // Overflow is recomputed every edge, so it naturally drops one edge after a wrap.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Output   <= '0;
      Overflow <= 1'b0;
    end else begin
      Overflow <= Enable && (Output == MaxCount);
      if (Enable) begin
        Output <= Output + NumOfBit'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter.sv
// Randomized and directed bench for counter at widths 1, 4 and 8 against
// an arithmetic modulo-2^W reference model.
module tb_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [0:0] out1;
  logic [3:0] out4;
  logic [7:0] out8;
  logic       ovf1;
  logic       ovf4;
  logic       ovf8;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned mcnt [3];
  int unsigned movf [3];
  int unsigned wid  [3];

  counter #(.NumOfBit(1)) u_c1 (.CLK(clk), .Reset(rst), .Enable(en), .Output(out1), .Overflow(ovf1));
  counter #(.NumOfBit(4)) u_c4 (.CLK(clk), .Reset(rst), .Enable(en), .Output(out4), .Overflow(ovf4));
  counter #(.NumOfBit(8)) u_c8 (.CLK(clk), .Reset(rst), .Enable(en), .Output(out8), .Overflow(ovf8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/out1"}, 32'(out1), mcnt[0]);
    check({tag, "/ovf1"}, 32'(ovf1), movf[0]);
    check({tag, "/out4"}, 32'(out4), mcnt[1]);
    check({tag, "/ovf4"}, 32'(ovf4), movf[1]);
    check({tag, "/out8"}, 32'(out8), mcnt[2]);
    check({tag, "/ovf8"}, 32'(ovf8), movf[2]);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      movf[k] = 0;
    end
  endfunction

  // One clock edge: the counter advances modulo 2^W; a pulse marks the edge that lands on 0.
  function automatic void model_edge(input bit e);
    for (int k = 0; k < 3; k++) begin
      int unsigned modulus;
      modulus = 32'd1 << wid[k];
      if (e) begin
        mcnt[k] = (mcnt[k] + 1) % modulus;
        movf[k] = (mcnt[k] == 0) ? 1 : 0;
      end else begin
        movf[k] = 0;
      end
    end
  endfunction

  // Called mid-cycle; leaves time at one unit after the sampled edge.
  task automatic step(input bit e, input string tag);
    en = e;
    @(posedge clk);
    model_edge(e);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse raised between edges, held across one edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "/async"});
    @(posedge clk);
    #1;
    check_all({tag, "/held"});
    #2 rst = 1'b0;
  endtask

  initial begin
    wid[0] = 1;
    wid[1] = 4;
    wid[2] = 8;
    model_reset();
    rst = 1'b1;
    en  = 1'b1;

    // Reset for 40 ns with Enable high: reset must dominate.
    #20;
    check_all("in_reset");
    #20 rst = 1'b0;

    // Full range: 256 edges wraps the 8-bit counter; narrow ones wrap many times.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, "full");
      if (i == 0)   check("first_inc", 32'(out8), 1);
      if (i == 255) check("wrap_out0", 32'(out8), 0);
      if (i == 255) check("wrap_ovf1", 32'(ovf8), 1);
    end
    step(1'b1, "post_wrap");
    check("post_wrap_ovf0", 32'(ovf8), 0);
    check("post_wrap_out1", 32'(out8), 1);

    // Enable gating at 0x37.
    for (int i = 0; i < 300 && mcnt[2] != 32'h37; i++) step(1'b1, "to37");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, "gate");
      check("gate_hold", 32'(out8), 32'h37);
    end
    step(1'b1, "regate");
    check("regate_38", 32'(out8), 32'h38);

    // Hold at max with Enable low: no overflow.
    for (int i = 0; i < 300 && mcnt[2] != 32'hFF; i++) step(1'b1, "toFF");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, "holdmax");
      check("holdmax_out", 32'(out8), 32'hFF);
      check("holdmax_ovf", 32'(ovf8), 0);
    end
    step(1'b1, "maxwrap");
    check("maxwrap_out", 32'(out8), 0);
    check("maxwrap_ovf", 32'(ovf8), 1);

    // Asynchronous reset while Overflow is high.
    async_reset("midpulse");
    check("midpulse_out", 32'(out8), 0);
    check("midpulse_ovf", 32'(ovf8), 0);
    step(1'b1, "after_rst");
    check("after_rst_out1", 32'(out8), 1);

    // Randomized enable with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(63) == 0) async_reset("rand");
      else step(($urandom_range(3) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
